mult: RTL and testbench
=======================

// Module: mult
// PURPOSE
//  Pipelined unsigned 64x64 integer multiplier for the integer multiply
//  functional unit of the OoO core.
//  - Returns the low 64 bits of mcand*mplier (modulo 2^64).
//  - Operands are captured on a start pulse; done is raised NUM_STAGES
//    cycles later.
//  - Accepts a new operation every cycle (fully pipelined).
// PARAMETERS
//  NUM_STAGES  8  pipeline depth; must divide 64; each stage handles 64/NUM_STAGES mplier bits
// PORTS
//  clock    in   1   single system clock, all state updates on rising edge
//  reset    in   1   asynchronous, active-low reset
//  mcand    in   64  multiplicand, unsigned
//  mplier   in   64  multiplier, unsigned
//  start    in   1   launch op with current mcand/mplier at this rising edge
//  product  out  64  low 64 bits of mcand*mplier; valid while done=1
//  done     out  1   registered; high for exactly one cycle per accepted start
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): clear every stage valid bit and every
//    partial product/operand register to 0.
//    - product=0, done=0 immediately; held until reset deasserts.
//    - Reset mid-operation discards all in-flight ops; no done for them.
//  - Stage k (0..NUM_STAGES-1), with W = 64/NUM_STAGES:
//    - register partial += mcand_k * mplier_k[W-1:0] (64-bit, wraps);
//    - register mcand_{k+1} = mcand_k << W and mplier_{k+1} = mplier_k >> W;
//    - register valid_{k+1} = valid_k.
//    - Stage 0 input: partial=0, mcand, mplier, valid=start.
//  - Latency: start sampled high at edge E0 -> done=1 after edge
//    E0+NUM_STAGES-1 (NUM_STAGES rising edges including E0), for one cycle.
//  - product = last-stage partial register; done = last-stage valid.
//    Both are driven from flops, no combinational path from inputs.
//  - mcand/mplier are sampled only at the edge where start=1.
//    - They may change freely afterwards without affecting the result.
//  - Back-to-back: start high on consecutive edges yields done on
//    consecutive cycles, results in issue order.
//  - start held high N cycles = N independent ops.
//  - No stall/flush input: ops cannot be cancelled except by reset.
//  - All arithmetic is unsigned; overflow above bit 63 is dropped.
//    - Signedness handled outside.
//  - When done=0, product holds the last-stage register contents (don't care).
// TESTING
//  - Reset then start, a=2, b=3 -> done pulses once after NUM_STAGES edges; product=6.
//  - a=0, b=257 -> product=0.
//    a=64'hFFFF_FFFF_FFFF_FFFF, b=0 -> product=0.
//  - a=b=64'hFFFF_FFFF_FFFF_FFFF -> product=64'h0000_0000_0000_0001.
//    a=64'hFFFF_FFFF_FFFF_FFFF, b=3 -> product=64'hFFFF_FFFF_FFFF_FFFD.
//  - a=64'h5555_5555_5555_5555, b=64'hCCCC_CCCC_CCCC_CCCC -> product = low 64 bits of a*b.
//    - Bench compares against a reference a*b after every done.
//  - Back-to-back issue of 16 random 64-bit pairs on consecutive cycles:
//    - 16 consecutive done pulses;
//    - each product equals the low 64 bits of its a*b, in order.
//  - Assert reset (0) with 3 ops in flight -> done/product clear immediately.
//    - No done after release until a new start.

Source files
------------

// File: rtl/mult.sv
// mult: fully pipelined unsigned 64x64 multiplier that returns the low 64 product bits.
// Each stage consumes W multiplier bits. The multiplier register narrows by W bits per stage.
module mult #(
  parameter int NUM_STAGES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] mcand,
  input  logic [63:0] mplier,
  input  logic        start,
  output logic [63:0] product,
  output logic        done
);
  localparam int W = 64 / NUM_STAGES;
  genvar i;
  for (i = 0; i < NUM_STAGES; i++) begin : g_st
    logic [63:0]      mc;
    logic [63-i*W:0]  mp;
    logic [63:0]      acc_in;
    logic [63:0]      acc_q;
    logic             v_in;
    logic             v_q;
    if (i == 0) begin : g_in
      assign mc     = mcand;
      assign mp     = mplier;
      assign acc_in = '0;
      assign v_in   = start;
    end else begin : g_in
      // The multiplier bits already consumed are dropped, not carried along.
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          mc <= '0;
          mp <= '0;
        end else begin
          mc <= g_st[i-1].mc << W;
          mp <= g_st[i-1].mp[63-(i-1)*W:W];
        end
      assign acc_in = g_st[i-1].acc_q;
      assign v_in   = g_st[i-1].v_q;
    end
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        acc_q <= '0;
        v_q   <= 1'b0;
      end else begin
        acc_q <= acc_in + mc * 64'(mp[W-1:0]);
        v_q   <= v_in;
      end
  end
  assign product = g_st[NUM_STAGES-1].acc_q;
  assign done    = g_st[NUM_STAGES-1].v_q;
endmodule

// File: tb/tb_mult.sv
// tb_mult: randomized self-checking bench for mult against a plain a*b reference.
module tb_mult;
  localparam int NS = 8;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] mcand = '0;
  logic [63:0] mplier = '0;
  logic        start = 1'b0;
  logic [63:0] product;
  logic        done;
  int          n_chk = 0;
  int          n_fail = 0;

  mult #(.NUM_STAGES(NS)) dut (
    .clock(clock), .reset(reset), .mcand(mcand), .mplier(mplier),
    .start(start), .product(product), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    #2;
    n_chk++;
    if (done !== 1'b0 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: done=%b product=%h, want done=0 product=0", done, product);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    logic        early;
    exp = a * b;
    early = 1'b0;
    @(negedge clock);
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    mcand = rnd64();
    mplier = rnd64();
    for (int k = 1; k < NS; k++) begin
      @(negedge clock);
      if (done !== 1'b0) early = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    n_chk++;
    if (early || done !== 1'b1 || product !== exp) begin
      n_fail++;
      $display("FAIL %s: early=%b done=%b product=%h, want early=0 done=1 product=%h",
               name, early, done, product, exp);
    end
    @(negedge clock);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: done=%b one cycle later, want 0", name, done);
    end
  endtask

  task automatic test_directed();
    run_op("two_times_three", 64'd2, 64'd3);
    run_op("zero_mcand", 64'd0, 64'd257);
    run_op("zero_mplier", '1, 64'd0);
    run_op("ones_squared", '1, '1);
    run_op("ones_times_three", '1, 64'd3);
    run_op("alt_pattern", 64'h5555_5555_5555_5555, 64'hCCCC_CCCC_CCCC_CCCC);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) run_op("random_single", rnd64(), rnd64());
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    int          got;
    int          waited;
    got = 0;
    waited = 0;
    fork
      begin
        for (int j = 0; j < 16; j++) begin
          logic [63:0] a;
          logic [63:0] b;
          a = rnd64();
          b = rnd64();
          @(negedge clock);
          mcand = a;
          mplier = b;
          start = 1'b1;
          q.push_back(a * b);
        end
        @(negedge clock);
        start = 1'b0;
      end
      begin
        @(negedge clock);
        while (done !== 1'b1 && waited < 4 * NS) begin
          @(negedge clock);
          waited++;
        end
        while (done === 1'b1 && got < 20) begin
          logic [63:0] exp;
          exp = (q.size() > 0) ? q.pop_front() : 64'hx;
          n_chk++;
          if (product !== exp) begin
            n_fail++;
            $display("FAIL b2b_result %0d: product=%h, want %h", got, product, exp);
          end
          got++;
          @(negedge clock);
        end
      end
    join
    n_chk++;
    if (got !== 16) begin
      n_fail++;
      $display("FAIL b2b_count: consecutive done pulses=%0d, want 16", got);
    end
  endtask

  task automatic test_reset_inflight();
    int seen;
    seen = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      mcand = rnd64() | 64'd1;
      mplier = rnd64() | 64'd1;
      start = 1'b1;
    end
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if (done !== 1'b0 || product !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_inflight: done=%b product=%h, want done=0 product=0", done, product);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3 * NS; k++) begin
      @(negedge clock);
      if (done === 1'b1) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_discard: done pulses after release=%0d, want 0", seen);
    end
    run_op("after_reset", 64'd7, 64'd9);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
